// File: rtl/twall_ser_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : twall_ser_master_if                                              |
// | Purpose : Command and chip-word handshake bundle between the frame/config  |
// |           controller (master) and the TWALL serial master (slave).         |
// | Signals : cmd_valid/cmd_ready/cmd_type/cmd_read/cmd_num - command channel  |
// |           din_valid/din_ready/din                      - chip-word channel |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface twall_ser_master_if #(
  parameter int CHANNEL_NUM = 48,
  parameter int CNT_W       = 16
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_type;
  logic                   cmd_read;
  logic [CNT_W-1:0]       cmd_num;
  logic                   din_valid;
  logic                   din_ready;
  logic [CHANNEL_NUM-1:0] din;

  // Controller side: issues commands and supplies chip words.
  modport master (
    output cmd_valid, cmd_type, cmd_read, cmd_num, din_valid, din,
    input  cmd_ready, din_ready
  );

  // Serial master side: accepts commands and pops chip words.
  modport slave (
    input  cmd_valid, cmd_type, cmd_read, cmd_num, din_valid, din,
    output cmd_ready, din_ready
  );
endinterface
`default_nettype wire

// File: rtl/twall_ser_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : twall_ser_master                                                 |
// | Purpose : Serial command master for the TWALL LED-driver daisy chain.      |
// |           Shifts CHIP_NUM x CHANNEL_NUM bits MSB-first on dck/sin with     |
// |           lat over the last N dck pulses, issues LAT-only sequences and    |
// |           counted gck bursts.                                              |
// | Ports   : clk, rst (async, active high)                                    |
// |           bus        - command + chip-word handshakes (slave modport)      |
// |           cfg_div    - dck half-period minus one                           |
// |           cfg_gck_div- gck half-period minus one                           |
// |           cfg_gap_wr/cfg_gap_rd - idle clks before first dck, minus one    |
// |           dck, sin, lat, gck - registered chain pins                       |
// |           busy       - FSM not idle                                        |
// |           done       - one-clk pulse on return to idle                     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module twall_ser_master #(
  parameter int CHIP_NUM    = 4,
  parameter int CHANNEL_NUM = 48,
  parameter int DIV_W       = 8,
  parameter int GAP_W       = 8,
  parameter int CNT_W       = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  twall_ser_master_if.slave     bus,
  input  wire logic [DIV_W-1:0] cfg_div,
  input  wire logic [DIV_W-1:0] cfg_gck_div,
  input  wire logic [GAP_W-1:0] cfg_gap_wr,
  input  wire logic [GAP_W-1:0] cfg_gap_rd,
  output logic                  dck,
  output logic                  sin,
  output logic                  lat,
  output logic                  gck,
  output logic                  busy,
  output logic                  done
);

  // Phase counter must hold a gap value or a doubled dck half-period.
  localparam int c_ph_w   = (DIV_W + 1 > GAP_W) ? DIV_W + 1 : GAP_W;
  localparam int c_wbit_w = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

  localparam logic [CNT_W-1:0]    c_total     = CNT_W'(CHIP_NUM * CHANNEL_NUM);
  localparam logic [CNT_W-1:0]    c_cnt_one   = CNT_W'(1);
  localparam logic [c_ph_w-1:0]   c_ph_one    = c_ph_w'(1);
  localparam logic [c_wbit_w-1:0] c_wbit_last = c_wbit_w'(CHANNEL_NUM - 1);
  localparam logic [c_wbit_w-1:0] c_wbit_one  = c_wbit_w'(1);

  localparam logic [1:0] c_cmd_write = 2'd0;
  localparam logic [1:0] c_cmd_lat   = 2'd1;
  localparam logic [1:0] c_cmd_gck   = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_GAP       = 4'd1,
    S_LOAD      = 4'd2,
    S_SHIFT_LO  = 4'd3,
    S_SHIFT_HI  = 4'd4,
    S_TAIL      = 4'd5,
    S_LAT_PULSE = 4'd6,
    S_GCK       = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  state_t                 r_state,     w_state_nxt;
  logic                   r_is_write,  w_is_write_nxt;
  logic [CNT_W-1:0]       r_num,       w_num_nxt;
  logic [CNT_W-1:0]       r_bit_cnt,   w_bit_cnt_nxt;
  logic [c_wbit_w-1:0]    r_wbit,      w_wbit_nxt;
  logic [c_ph_w-1:0]      r_cnt,       w_cnt_nxt;
  logic [CHANNEL_NUM-1:0] r_shreg,     w_shreg_nxt;
  logic                   r_dck,       w_dck_nxt;
  logic                   r_sin,       w_sin_nxt;
  logic                   r_lat,       w_lat_nxt;
  logic                   r_gck,       w_gck_nxt;
  logic                   r_din_ready, w_din_ready_nxt;

  logic [CNT_W-1:0] w_bit_dec;
  assign w_bit_dec = r_bit_cnt - c_cnt_one;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_is_write  <= 1'b0;
      r_num       <= '0;
      r_bit_cnt   <= '0;
      r_wbit      <= '0;
      r_cnt       <= '0;
      r_shreg     <= '0;
      r_dck       <= 1'b0;
      r_sin       <= 1'b0;
      r_lat       <= 1'b0;
      r_gck       <= 1'b0;
      r_din_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_is_write  <= w_is_write_nxt;
      r_num       <= w_num_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_wbit      <= w_wbit_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shreg     <= w_shreg_nxt;
      r_dck       <= w_dck_nxt;
      r_sin       <= w_sin_nxt;
      r_lat       <= w_lat_nxt;
      r_gck       <= w_gck_nxt;
      r_din_ready <= w_din_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_is_write_nxt  = r_is_write;
    w_num_nxt       = r_num;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_wbit_nxt      = r_wbit;
    w_cnt_nxt       = r_cnt;
    w_shreg_nxt     = r_shreg;
    w_dck_nxt       = r_dck;
    w_sin_nxt       = r_sin;
    w_lat_nxt       = r_lat;
    w_gck_nxt       = r_gck;
    w_din_ready_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_type)
            c_cmd_write: begin
              w_is_write_nxt = 1'b1;
              w_num_nxt      = (bus.cmd_num > c_total) ? c_total : bus.cmd_num;
              w_bit_cnt_nxt  = c_total - c_cnt_one;
              w_wbit_nxt     = c_wbit_last;
              w_cnt_nxt      = bus.cmd_read ? c_ph_w'(cfg_gap_rd) : c_ph_w'(cfg_gap_wr);
              w_state_nxt    = S_GAP;
            end
            c_cmd_lat: begin
              w_is_write_nxt = 1'b0;
              w_num_nxt      = bus.cmd_num;
              w_sin_nxt      = 1'b0;
              w_lat_nxt      = 1'b1;
              if (bus.cmd_num == '0) begin
                // Counter preset to 2*(cfg_div+1)-1 for a lone lat pulse.
                w_cnt_nxt   = c_ph_w'({cfg_div, 1'b1});
                w_state_nxt = S_LAT_PULSE;
              end else begin
                w_bit_cnt_nxt = bus.cmd_num - c_cnt_one;
                w_cnt_nxt     = c_ph_w'(cfg_div);
                w_state_nxt   = S_SHIFT_LO;
              end
            end
            c_cmd_gck: begin
              if (bus.cmd_num == '0) begin
                w_state_nxt = S_DONE;
              end else begin
                // Bit counter reused as remaining gck periods.
                w_bit_cnt_nxt = bus.cmd_num;
                w_cnt_nxt     = c_ph_w'(cfg_gck_div);
                w_gck_nxt     = 1'b1;
                w_state_nxt   = S_GCK;
              end
            end
            default: w_state_nxt = S_DONE;
          endcase
        end
      end

      S_GAP: begin
        if (r_cnt == '0) w_state_nxt = S_LOAD;
        else             w_cnt_nxt   = r_cnt - c_ph_one;
      end

      S_LOAD: begin
        if (bus.din_valid) begin
          w_shreg_nxt     = bus.din << 1;
          w_sin_nxt       = bus.din[CHANNEL_NUM-1];
          w_din_ready_nxt = 1'b1;
          w_cnt_nxt       = c_ph_w'(cfg_div);
          w_state_nxt     = S_SHIFT_LO;
          if (r_bit_cnt < r_num) w_lat_nxt = 1'b1;
        end
      end

      S_SHIFT_LO: begin
        if (r_cnt == '0) begin
          w_dck_nxt   = 1'b1;
          w_cnt_nxt   = c_ph_w'(cfg_div);
          w_state_nxt = S_SHIFT_HI;
        end else begin
          w_cnt_nxt = r_cnt - c_ph_one;
        end
      end

      S_SHIFT_HI: begin
        if (r_cnt == '0) begin
          w_dck_nxt = 1'b0;
          w_cnt_nxt = c_ph_w'(cfg_div);
          if (r_bit_cnt == '0) begin
            w_state_nxt = S_TAIL;
          end else begin
            w_bit_cnt_nxt = w_bit_dec;
            if (r_is_write && r_wbit == '0) begin
              // Word exhausted: fetch the next one; lat decision made in LOAD.
              w_wbit_nxt  = c_wbit_last;
              w_state_nxt = S_LOAD;
            end else begin
              w_state_nxt = S_SHIFT_LO;
              if (r_is_write) begin
                w_wbit_nxt  = r_wbit - c_wbit_one;
                w_sin_nxt   = r_shreg[CHANNEL_NUM-1];
                w_shreg_nxt = r_shreg << 1;
              end
              if (w_bit_dec < r_num) w_lat_nxt = 1'b1;
            end
          end
        end else begin
          w_cnt_nxt = r_cnt - c_ph_one;
        end
      end

      S_TAIL: begin
        if (r_cnt == '0) begin
          w_lat_nxt   = 1'b0;
          w_sin_nxt   = 1'b0;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - c_ph_one;
        end
      end

      S_LAT_PULSE: begin
        if (r_cnt == '0) begin
          w_lat_nxt   = 1'b0;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - c_ph_one;
        end
      end

      S_GCK: begin
        if (r_cnt == '0) begin
          w_cnt_nxt = c_ph_w'(cfg_gck_div);
          if (r_gck) begin
            w_gck_nxt = 1'b0;
          end else if (r_bit_cnt == c_cnt_one) begin
            w_state_nxt = S_DONE;
          end else begin
            w_bit_cnt_nxt = w_bit_dec;
            w_gck_nxt     = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - c_ph_one;
        end
      end

      S_DONE:  w_state_nxt = S_IDLE;

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign dck           = r_dck;
  assign sin           = r_sin;
  assign lat           = r_lat;
  assign gck           = r_gck;
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.din_ready = r_din_ready;

endmodule
`default_nettype wire

// File: tb/tb_twall_ser_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_twall_ser_master                                              |
// | Purpose : Directed vector bench for twall_ser_master with a 2-chip x       |
// |           4-channel chain; counts pin activity per command and compares    |
// |           against hand-computed totals.                                    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_twall_ser_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cfg_div, cfg_gck_div, cfg_gap_wr, cfg_gap_rd;
  logic       dck, sin, lat, gck, busy, done;

  int n_err    = 0;
  int n_checks = 0;

  twall_ser_master_if #(.CHANNEL_NUM(4), .CNT_W(16)) bus ();

  twall_ser_master #(
    .CHIP_NUM(2), .CHANNEL_NUM(4), .DIV_W(8), .GAP_W(8), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cfg_div(cfg_div), .cfg_gck_div(cfg_gck_div),
    .cfg_gap_wr(cfg_gap_wr), .cfg_gap_rd(cfg_gap_rd),
    .dck(dck), .sin(sin), .lat(lat), .gck(gck), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ctype;
    logic [15:0] num;
    logic        rd;
    logic [7:0]  div;
    logic [7:0]  gdiv;
    logic [3:0]  w0;
    logic [3:0]  w1;
    int          stall_at;  // busy cycle at which din_valid returns for word 2 (0 = no stall)
    int          e_bits;    // sin sampled at each dck rise, first bit in MSB position
    int          e_dck;
    int          e_latrise; // dck rises seen with lat=1
    int          e_latclk;
    int          e_gck;
    int          e_busy;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Issues one command from a negedge and tallies pin activity until done.
  task automatic run_vec(input vec_t v, input string tag);
    int   busy_c = 0, dck_r = 0, lat_r = 0, lat_c = 0, gck_r = 0, done_c = 0;
    int   bits = 0, wi = 0;
    logic pd = 1'b0, pg = 1'b0;
    bit   fin = 1'b0;
    cfg_div            = v.div;
    cfg_gck_div        = v.gdiv;
    bus.cmd_type       = v.ctype;
    bus.cmd_num        = v.num;
    bus.cmd_read       = v.rd;
    bus.din            = v.w0;
    bus.din_valid      = 1'b1;
    bus.cmd_valid      = 1'b1;
    @(negedge clk);
    // Disturb the command fields after acceptance; they must be ignored.
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = 2'd2;
    bus.cmd_num   = 16'hFFFF;
    bus.cmd_read  = ~v.rd;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (busy) busy_c++;
      if (dck && !pd) begin
        dck_r++;
        bits = (bits << 1) | int'(sin);
        if (lat) lat_r++;
      end
      if (lat) lat_c++;
      if (gck && !pg) gck_r++;
      if (done) done_c++;
      pd = dck;
      pg = gck;
      if (bus.din_ready) begin
        wi++;
        bus.din = (wi == 1) ? v.w1 : 4'h0;
        if (v.stall_at != 0 && wi == 1) bus.din_valid = 1'b0;
      end
      if (v.stall_at != 0 && busy_c == v.stall_at) bus.din_valid = 1'b1;
      if (done) fin = 1'b1;
      else      @(negedge clk);
    end
    if (!fin) begin
      n_checks++;
      n_err++;
      $display("FAIL %s.timeout: got no done expected done", tag);
    end
    check({tag, ".bits"},    bits,   v.e_bits);
    check({tag, ".dck"},     dck_r,  v.e_dck);
    check({tag, ".latrise"}, lat_r,  v.e_latrise);
    check({tag, ".latclk"},  lat_c,  v.e_latclk);
    check({tag, ".gck"},     gck_r,  v.e_gck);
    check({tag, ".busy"},    busy_c, v.e_busy);
    check({tag, ".done"},    done_c, 1);
    @(negedge clk);
    check({tag, ".idle"}, int'({dck, sin, lat, gck, busy, done, bus.cmd_ready}), 1);
  endtask

  vec_t vt[11];
  vec_t vpost;

  initial begin
    //        type  num   rd  div  gdiv w0    w1    stall bits   dck lr lc  gck busy
    vt[0]  = '{2'd0, 16'd0, 1'b0, 8'd1, 8'd0, 4'hA, 4'h5, 0,  'hA5, 8, 0, 0,  0, 41};
    vt[1]  = '{2'd0, 16'd3, 1'b0, 8'd1, 8'd0, 4'hA, 4'h5, 0,  'hA5, 8, 3, 14, 0, 41};
    vt[2]  = '{2'd0, 16'd0, 1'b0, 8'd1, 8'd0, 4'hA, 4'h5, 32, 'hA5, 8, 0, 0,  0, 51};
    vt[3]  = '{2'd0, 16'd3, 1'b1, 8'd0, 8'd0, 4'hC, 4'h3, 0,  'hC3, 8, 3, 7,  0, 21};
    vt[4]  = '{2'd1, 16'd0, 1'b0, 8'd2, 8'd0, 4'hF, 4'hF, 0,  0,    0, 0, 6,  0, 7};
    vt[5]  = '{2'd1, 16'd2, 1'b0, 8'd1, 8'd0, 4'hF, 4'hF, 0,  0,    2, 2, 10, 0, 11};
    vt[6]  = '{2'd2, 16'd5, 1'b0, 8'd1, 8'd0, 4'hF, 4'hF, 0,  0,    0, 0, 0,  5, 11};
    vt[7]  = '{2'd2, 16'd0, 1'b0, 8'd1, 8'd0, 4'hF, 4'hF, 0,  0,    0, 0, 0,  0, 1};
    vt[8]  = '{2'd3, 16'd7, 1'b0, 8'd1, 8'd0, 4'hF, 4'hF, 0,  0,    0, 0, 0,  0, 1};
    vt[9]  = '{2'd0, 16'd8, 1'b0, 8'd1, 8'd0, 4'hA, 4'h5, 0,  'hA5, 8, 8, 35, 0, 41};
    vt[10] = '{2'd2, 16'd2, 1'b0, 8'd1, 8'd2, 4'hF, 4'hF, 0,  0,    0, 0, 0,  2, 13};
    vpost  = '{2'd0, 16'd100, 1'b0, 8'd1, 8'd0, 4'h6, 4'h9, 0, 'h69, 8, 8, 35, 0, 41};

    cfg_div = 8'd1; cfg_gck_div = 8'd0; cfg_gap_wr = 8'd3; cfg_gap_rd = 8'd0;
    bus.cmd_valid = 1'b0; bus.cmd_type = 2'd0; bus.cmd_read = 1'b0; bus.cmd_num = '0;
    bus.din_valid = 1'b0; bus.din = '0;

    // Reset state: only cmd_ready high.
    repeat (2) @(negedge clk);
    check("reset.outs", int'({dck, sin, lat, gck, busy, done, bus.din_ready, bus.cmd_ready}), 1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // Abort mid-shift while lat is high.
    begin
      bit hit = 1'b0;
      cfg_div = 8'd1;
      bus.cmd_type = 2'd0; bus.cmd_num = 16'd8; bus.cmd_read = 1'b0;
      bus.din = 4'hA; bus.din_valid = 1'b1; bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
        if (dck && lat) hit = 1'b1;
        else            @(negedge clk);
      end
      check("abort.reached", int'(hit), 1);
      #2 rst = 1'b1;
      #1;
      check("abort.pins", int'({dck, sin, lat, gck, busy, done, bus.din_ready}), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort.ready", int'({bus.cmd_ready, busy, dck, lat}), 8);
      run_vec(vpost, "post");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
